tt_ldb: RTL and testbench

Load Data Buffer for the vector memory path: the responder for the issue FIFO's `ldb_alloc_valid`/`ldb_alloc_ack` allocation handshake. It reserves contiguous line storage per vector load (keyed by scoreboard id), captures returned load data lines in any order within a load, and drains them in allocation order to the Ocelot VPU load writeback. It sits between the OVI load-return path and the VPU, alongside the issue FIFO.

---
 rtl/tt_briscv_pkg.sv | 27 ++
 rtl/tt_ldb_alloc_table.sv | 82 ++++++++
 rtl/tt_ldb.sv | 105 ++++++++++
 tb/tb_tt_ldb.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_briscv_pkg.sv
// rtl/tt_briscv_pkg.sv - shared types and constants for the vector load data buffer
package tt_briscv_pkg;

    localparam int LDB_SB_ID_W = 5;
    localparam int LDB_SIZE_W  = 4;
    localparam int LDB_IDX_W   = 3;
    // Wide enough for any supported DEPTH; consumers truncate to their own line address width.
    localparam int LDB_BASE_W  = 8;

    localparam logic [LDB_SIZE_W-1:0] LDB_SIZE_1 = 4'd1;
    localparam logic [LDB_SIZE_W-1:0] LDB_SIZE_2 = 4'd2;
    localparam logic [LDB_SIZE_W-1:0] LDB_SIZE_4 = 4'd4;
    localparam logic [LDB_SIZE_W-1:0] LDB_SIZE_8 = 4'd8;

    typedef struct packed {
        logic [LDB_SB_ID_W-1:0] sb_id;
        logic [LDB_BASE_W-1:0]  base;
        logic [LDB_SIZE_W-1:0]  size;
        logic                   live;
    } ldb_alloc_entry_t;

    function automatic logic ldb_size_legal(input logic [LDB_SIZE_W-1:0] size);
        return (size == LDB_SIZE_1) || (size == LDB_SIZE_2) ||
               (size == LDB_SIZE_4) || (size == LDB_SIZE_8);
    endfunction

endpackage

// File: rtl/tt_ldb_alloc_table.sv
// rtl/tt_ldb_alloc_table.sv - allocation queue, sb_id CAM and ack decision for tt_ldb
module tt_ldb_alloc_table
    import tt_briscv_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NALLOC = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_valid,
    input  logic [LDB_SB_ID_W-1:0]   alloc_sb_id,
    input  logic [LDB_SIZE_W-1:0]    alloc_size,
    output logic                     alloc_ack,
    output logic                     alloc_err,
    input  logic                     pop,
    output ldb_alloc_entry_t         head_entry,
    output logic                     empty,
    input  logic [LDB_SB_ID_W-1:0]   wr_sb_id,
    output logic                     wr_hit,
    output ldb_alloc_entry_t         wr_entry,
    output logic [$clog2(DEPTH):0]   free_lines
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int PW = $clog2(NALLOC);
    localparam logic [PW:0] PTR_ONE = 1;

    ldb_alloc_entry_t tbl [NALLOC];
    logic [PW:0]      head;
    logic [PW:0]      tail;
    logic [AW-1:0]    alloc_ptr;
    logic             full;
    logic             dup;
    logic             size_ok;

    // Queue status, sb_id CAM lookups for both the requester and the write port, ack decision.
    always_comb begin
        empty      = (head == tail);
        full       = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);
        head_entry = tbl[head[PW-1:0]];
        dup        = 1'b0;
        wr_hit     = 1'b0;
        wr_entry   = '0;
        for (int i = 0; i < NALLOC; i++) begin
            if (tbl[i].live && (tbl[i].sb_id == alloc_sb_id)) dup = 1'b1;
            if (tbl[i].live && (tbl[i].sb_id == wr_sb_id)) begin
                wr_hit   = 1'b1;
                wr_entry = tbl[i];
            end
        end
        size_ok   = ldb_size_legal(alloc_size);
        // Uses registered free_lines and occupancy so freed credit is only usable the cycle after a pop.
        alloc_ack = alloc_valid && size_ok && (free_lines >= FW'(alloc_size)) && !full && !dup;
        alloc_err = alloc_valid && (!size_ok || dup);
    end

    // Push on ack, retire head on final pop, keep line credit and the contiguous allocation pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            alloc_ptr  <= '0;
            free_lines <= FW'(DEPTH);
            for (int i = 0; i < NALLOC; i++) tbl[i] <= '0;
        end else begin
            if (pop) begin
                tbl[head[PW-1:0]].live <= 1'b0;
                head <= head + PTR_ONE;
            end
            if (alloc_ack) begin
                tbl[tail[PW-1:0]] <= '{sb_id: alloc_sb_id, base: LDB_BASE_W'(alloc_ptr),
                                       size: alloc_size, live: 1'b1};
                tail      <= tail + PTR_ONE;
                alloc_ptr <= alloc_ptr + AW'(alloc_size);
            end
            free_lines <= free_lines + (pop ? FW'(head_entry.size) : '0)
                                     - (alloc_ack ? FW'(alloc_size) : '0);
        end
    end

endmodule

// File: rtl/tt_ldb.sv
// rtl/tt_ldb.sv - load data buffer top; optional same-cycle write bypass under TT_LDB_WR_BYPASS_EN
module tt_ldb
    import tt_briscv_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NALLOC = 4,
    parameter int DATA_W = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ldb_alloc_valid,
    input  logic [4:0]              ldb_alloc_sb_id,
    input  logic [3:0]              ldb_alloc_size,
    output logic                    ldb_alloc_ack,
    input  logic                    ld_wr_valid,
    input  logic [4:0]              ld_wr_sb_id,
    input  logic [2:0]              ld_wr_idx,
    input  logic [DATA_W-1:0]       ld_wr_data,
    input  logic                    rd_req,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic [4:0]              rd_sb_id,
    output logic                    rd_last,
    output logic [$clog2(DEPTH):0]  free_lines,
    output logic                    err
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DEPTH-1:0]     filled;
    logic [LDB_IDX_W-1:0] rd_idx;
    ldb_alloc_entry_t     head_entry;
    ldb_alloc_entry_t     wr_entry;
    logic                 tbl_empty;
    logic                 wr_hit;
    logic                 alloc_err;
    logic [AW-1:0]        head_line;
    logic [AW-1:0]        wr_line;
    logic                 wr_ok;
    logic                 wr_err;
    logic                 byp;
    logic                 pop;
    logic                 final_pop;
    logic                 unused_fields;

    tt_ldb_alloc_table #(.DEPTH(DEPTH), .NALLOC(NALLOC)) u_alloc_table (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (ldb_alloc_valid),
        .alloc_sb_id (ldb_alloc_sb_id),
        .alloc_size  (ldb_alloc_size),
        .alloc_ack   (ldb_alloc_ack),
        .alloc_err   (alloc_err),
        .pop         (final_pop),
        .head_entry  (head_entry),
        .empty       (tbl_empty),
        .wr_sb_id    (ld_wr_sb_id),
        .wr_hit      (wr_hit),
        .wr_entry    (wr_entry),
        .free_lines  (free_lines)
    );

    assign unused_fields = ^{head_entry, wr_entry};

    // Line addressing, write validation and head-of-queue read presentation.
    always_comb begin
        head_line = AW'(head_entry.base) + AW'(rd_idx);
        wr_line   = AW'(wr_entry.base) + AW'(ld_wr_idx);
        wr_ok     = ld_wr_valid && wr_hit && ({1'b0, ld_wr_idx} < wr_entry.size) && !filled[wr_line];
        wr_err    = ld_wr_valid && !wr_ok;
`ifdef TT_LDB_WR_BYPASS_EN
        byp       = wr_ok && !tbl_empty && (wr_line == head_line);
`else
        byp       = 1'b0;
`endif
        rd_valid  = !tbl_empty && (filled[head_line] || byp);
        rd_data   = byp ? ld_wr_data : mem[head_line];
        rd_sb_id  = tbl_empty ? '0 : head_entry.sb_id;
        rd_last   = !tbl_empty && ({1'b0, rd_idx} == (head_entry.size - 4'd1));
        pop       = rd_req && rd_valid;
        final_pop = pop && rd_last;
    end

    // Filled bits, head read index and the sticky protocol error.
    always_ff @(posedge clk) begin
        if (reset) begin
            filled <= '0;
            rd_idx <= '0;
            err    <= 1'b0;
        end else begin
            if (pop) filled[head_line] <= 1'b0;
            // A bypassed line that is consumed immediately never becomes filled.
            if (wr_ok && !(byp && pop)) filled[wr_line] <= 1'b1;
            if (pop) rd_idx <= rd_last ? '0 : rd_idx + 3'd1;
            if (alloc_err || wr_err) err <= 1'b1;
        end
    end

    // Line data storage; contents are don't-care until marked filled.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_line] <= ld_wr_data;
    end

endmodule

// File: tb/tb_tt_ldb.sv
// tb/tb_tt_ldb.sv - self-checking bench for tt_ldb against a queue-based reference model
module tb_tt_ldb;

    localparam int DEPTH  = 16;
    localparam int NALLOC = 4;
    localparam int DATA_W = 512;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ldb_alloc_valid = 1'b0;
    logic [4:0]        ldb_alloc_sb_id = '0;
    logic [3:0]        ldb_alloc_size = '0;
    logic              ldb_alloc_ack;
    logic              ld_wr_valid = 1'b0;
    logic [4:0]        ld_wr_sb_id = '0;
    logic [2:0]        ld_wr_idx = '0;
    logic [DATA_W-1:0] ld_wr_data = '0;
    logic              rd_req = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        rd_sb_id;
    logic              rd_last;
    logic [4:0]        free_lines;
    logic              err;

    tt_ldb #(.DEPTH(DEPTH), .NALLOC(NALLOC), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .ldb_alloc_valid (ldb_alloc_valid),
        .ldb_alloc_sb_id (ldb_alloc_sb_id),
        .ldb_alloc_size  (ldb_alloc_size),
        .ldb_alloc_ack   (ldb_alloc_ack),
        .ld_wr_valid     (ld_wr_valid),
        .ld_wr_sb_id     (ld_wr_sb_id),
        .ld_wr_idx       (ld_wr_idx),
        .ld_wr_data      (ld_wr_data),
        .rd_req          (rd_req),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_sb_id        (rd_sb_id),
        .rd_last         (rd_last),
        .free_lines      (free_lines),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of outstanding loads plus a flat line store.
    int                q_sb[$];
    int                q_size[$];
    int                q_base[$];
    int                m_ptr, m_free, m_idx;
    bit                m_err;
    bit                m_last_ack;
    logic [DATA_W-1:0] m_data [DEPTH];
    bit                m_filled [DEPTH];

    function automatic bit legal(input int s);
        return (s == 1) || (s == 2) || (s == 4) || (s == 8);
    endfunction

    function automatic int find(input int sb);
        foreach (q_sb[i]) if (q_sb[i] == sb) return i;
        return -1;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_line();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        q_sb.delete(); q_size.delete(); q_base.delete();
        m_ptr = 0; m_free = DEPTH; m_idx = 0; m_err = 0; m_last_ack = 0;
        for (int i = 0; i < DEPTH; i++) m_filled[i] = 0;
    endtask

    task automatic idle();
        ldb_alloc_valid = 0; ld_wr_valid = 0; rd_req = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    // One clock: compare DUT outputs to the model at the falling edge, then advance the model.
    task automatic cyc();
        int pos, hl, wl, sz0;
        bit dup, exp_ack, wr_ok, byp, exp_rv, exp_last, pop;
        @(negedge clk);
        dup     = find(ldb_alloc_sb_id) >= 0;
        exp_ack = ldb_alloc_valid && legal(ldb_alloc_size) && (m_free >= ldb_alloc_size)
                  && (q_sb.size() < NALLOC) && !dup;
        pos   = find(ld_wr_sb_id);
        wl    = 0;
        wr_ok = 0;
        if (ld_wr_valid && pos >= 0) begin
            wl = (q_base[pos] + ld_wr_idx) % DEPTH;
            wr_ok = (ld_wr_idx < q_size[pos]) && !m_filled[wl];
        end
        hl = 0; exp_last = 0; exp_rv = 0; byp = 0;
        if (q_sb.size() > 0) begin
            hl = (q_base[0] + m_idx) % DEPTH;
            exp_last = (m_idx == q_size[0] - 1);
`ifdef TT_LDB_WR_BYPASS_EN
            byp = wr_ok && (wl == hl);
`endif
            exp_rv = m_filled[hl] || byp;
        end
        check("alloc_ack", ldb_alloc_ack, exp_ack);
        check("rd_valid", rd_valid, exp_rv);
        check("free_lines", free_lines, m_free);
        check("err", err, m_err);
        if (exp_rv) begin
            check("rd_data", rd_data, byp ? ld_wr_data : m_data[hl]);
            check("rd_sb_id", rd_sb_id, q_sb[0]);
            check("rd_last", rd_last, exp_last);
        end
        pop = rd_req && exp_rv;
        m_last_ack = exp_ack;
        @(posedge clk);
        if (wr_ok) begin
            m_data[wl] = ld_wr_data;
            if (!(byp && pop)) m_filled[wl] = 1;
        end else if (ld_wr_valid) m_err = 1;
        if (ldb_alloc_valid && (!legal(ldb_alloc_size) || dup)) m_err = 1;
        if (pop) begin
            m_filled[hl] = 0;
            if (exp_last) begin
                sz0 = q_size[0];
                void'(q_sb.pop_front()); void'(q_size.pop_front()); void'(q_base.pop_front());
                m_free += sz0;
                m_idx = 0;
            end else m_idx++;
        end
        if (exp_ack) begin
            q_sb.push_back(ldb_alloc_sb_id);
            q_size.push_back(ldb_alloc_size);
            q_base.push_back(m_ptr);
            m_ptr = (m_ptr + ldb_alloc_size) % DEPTH;
            m_free -= ldb_alloc_size;
        end
        #1;
    endtask

    task automatic alloc(input int sb, input int size);
        ldb_alloc_valid = 1; ldb_alloc_sb_id = 5'(sb); ldb_alloc_size = 4'(size);
        cyc();
        ldb_alloc_valid = 0;
    endtask

    task automatic wr(input int sb, input int idx);
        ld_wr_valid = 1; ld_wr_sb_id = 5'(sb); ld_wr_idx = 3'(idx); ld_wr_data = rnd_line();
        cyc();
        ld_wr_valid = 0;
    endtask

    // Supply the next head line when missing and pop until the model queue empties.
    task automatic drain();
        int guard = 0;
        rd_req = 1;
        while (q_sb.size() > 0 && guard < 200) begin
            ld_wr_valid = 0;
            if (!m_filled[(q_base[0] + m_idx) % DEPTH]) begin
                ld_wr_valid = 1; ld_wr_sb_id = 5'(q_sb[0]); ld_wr_idx = 3'(m_idx);
                ld_wr_data = rnd_line();
            end
            cyc();
            guard++;
        end
        idle();
        check("drain_free", free_lines, DEPTH);
    endtask

    initial begin
        int guard, pos, idx, line;
        bit acked;
        do_reset();
        check("reset_free", free_lines, DEPTH);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_err", err, 0);

        // Out-of-order fill of one 4-line load, in-order drain.
        ldb_alloc_valid = 1; ldb_alloc_sb_id = 3; ldb_alloc_size = 4;
        #1 check("t1_ack_same_cycle", ldb_alloc_ack, 1);
        cyc();
        ldb_alloc_valid = 0;
        check("t1_free_after_alloc", free_lines, 12);
        wr(3, 3); wr(3, 1); wr(3, 0); wr(3, 2);
        rd_req = 1;
        for (int i = 0; i < 4; i++) cyc();
        rd_req = 0;
        check("t1_free_after_drain", free_lines, 16);

        // Credit starvation until the size-8 load drains; new allocation wraps.
        do_reset();
        alloc(10, 8); alloc(11, 4); alloc(12, 2);
        check("t2_free", free_lines, 2);
        ldb_alloc_valid = 1; ldb_alloc_sb_id = 13; ldb_alloc_size = 4;
        #1 check("t2_no_ack", ldb_alloc_ack, 0);
        acked = 0; guard = 0;
        rd_req = 1;
        while (!acked && guard < 60) begin
            ld_wr_valid = 0;
            if (!m_filled[(q_base[0] + m_idx) % DEPTH]) begin
                ld_wr_valid = 1; ld_wr_sb_id = 5'(q_sb[0]); ld_wr_idx = 3'(m_idx);
                ld_wr_data = rnd_line();
            end
            cyc();
            if (m_last_ack) begin acked = 1; ldb_alloc_valid = 0; end
            guard++;
        end
        check("t2_ack_seen", acked, 1);
        drain();

        // Full table stalls without error; a pop frees a slot next cycle.
        do_reset();
        for (int i = 1; i <= 4; i++) alloc(i, 1);
        ldb_alloc_valid = 1; ldb_alloc_sb_id = 5; ldb_alloc_size = 1;
        #1 check("t3_full_no_ack", ldb_alloc_ack, 0);
        cyc();
        check("t3_full_no_err", err, 0);
        ld_wr_valid = 1; ld_wr_sb_id = 1; ld_wr_idx = 0; ld_wr_data = rnd_line();
        cyc();
        ld_wr_valid = 0; rd_req = 1;
        cyc();
        rd_req = 0;
        #1 check("t3_ack_after_pop", ldb_alloc_ack, 1);
        cyc();
        ldb_alloc_valid = 0;
        drain();

        // Illegal size and unallocated write raise the sticky error.
        do_reset();
        ldb_alloc_valid = 1; ldb_alloc_sb_id = 7; ldb_alloc_size = 3;
        #1 check("t4_bad_size_no_ack", ldb_alloc_ack, 0);
        cyc();
        ldb_alloc_valid = 0;
        check("t4_bad_size_err", err, 1);
        do_reset();
        alloc(2, 2);
        wr(9, 0);
        check("t4_bad_wr_err", err, 1);
        check("t4_bad_wr_rd_valid", rd_valid, 0);

        // Write into the empty head line with rd_req held.
        do_reset();
        alloc(4, 2);
        ld_wr_valid = 1; ld_wr_sb_id = 4; ld_wr_idx = 0; ld_wr_data = rnd_line(); rd_req = 1;
`ifdef TT_LDB_WR_BYPASS_EN
        #1 check("t5_bypass_rd_valid", rd_valid, 1);
`else
        #1 check("t5_no_bypass_rd_valid", rd_valid, 0);
`endif
        cyc();
        ld_wr_valid = 0;
        cyc();
        drain();

        // Reset with live allocations and partial data discards everything.
        do_reset();
        alloc(20, 4); alloc(21, 2);
        wr(20, 0); wr(21, 1); wr(30, 0);
        check("t6_pre_err", err, 1);
        do_reset();
        check("t6_rd_valid", rd_valid, 0);
        check("t6_free", free_lines, 16);
        check("t6_err", err, 0);

        // Randomized legal traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 2) == 0) begin
                ldb_alloc_sb_id = 5'($urandom_range(0, 31));
                ldb_alloc_size = 4'(1 << $urandom_range(0, 3));
                ldb_alloc_valid = (find(ldb_alloc_sb_id) < 0);
            end
            if (q_sb.size() > 0 && $urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, q_sb.size() - 1);
                idx = $urandom_range(0, q_size[pos] - 1);
                line = (q_base[pos] + idx) % DEPTH;
                if (!m_filled[line]) begin
                    ld_wr_valid = 1; ld_wr_sb_id = 5'(q_sb[pos]); ld_wr_idx = 3'(idx);
                    ld_wr_data = rnd_line();
                end
            end
            rd_req = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
